dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_starve_cnt.sv | 40 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DATA_W = 32;

    // OPEN: master 0 has priority; LOCKED: master 1 owns the bus.
    typedef enum logic [0:0] {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Owner of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles master 1 was denied while the bus was open.
// Raises force_m1 once the count reaches STARVE_MAX and master 1 is still requesting.
module dmem_arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_open,
    input  logic m1_req,
    input  logic m1_gnt,
    output logic force_m1
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear on grant or withdrawn request, otherwise saturate-increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!m1_req || m1_gnt) begin
            cnt_d = '0;
        end else if (arb_open && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_m1 = m1_req && (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory port: core load/store (m0) and debug/DMA loader (m1).
// Optional anti-starvation for master 1 is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q;
    rd_owner_e  rd_owner_q;
    logic       arb_open;
    logic       force_m1;

    // The release cycle (lock dropped while LOCKED) is already arbitrated as open.
    assign arb_open = (state_q == OPEN) || !m1_lock;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_open (arb_open),
        .m1_req   (m1_req),
        .m1_gnt   (m1_gnt),
        .force_m1 (force_m1)
    );
`else
    assign force_m1 = 1'b0;
`endif

    // Grant decision: m0 priority when open unless m1 is starved; only m1 while locked.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (arb_open) begin
            if (force_m1) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end else begin
            m1_gnt = m1_req;
        end
    end

    // Memory port mux of the granted master; quiet when nobody is granted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
        end
    end

    assign mem_en = m0_gnt | m1_gnt;

    // Lock FSM and read-ownership tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OPEN;
            rd_owner_q <= OWN_NONE;
        end else begin
            if (m1_lock && ((state_q == LOCKED) || m1_gnt)) begin
                state_q <= LOCKED;
            end else begin
                state_q <= OPEN;
            end
            if (m0_gnt && !m0_we) begin
                rd_owner_q <= OWN_M0;
            end else if (m1_gnt && !m1_we) begin
                rd_owner_q <= OWN_M1;
            end else begin
                rd_owner_q <= OWN_NONE;
            end
        end
    end

    assign m0_rvalid = (rd_owner_q == OWN_M0);
    assign m1_rvalid = (rd_owner_q == OWN_M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus read-response scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned STARVE_MAX = 8;

    typedef struct {
        logic        m0_req;
        logic        m0_we;
        logic [11:0] m0_addr;
        logic [31:0] m0_wdata;
        logic [3:0]  m0_be;
        logic        m1_req;
        logic        m1_we;
        logic [11:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_be;
        logic        m1_lock;
        logic        e0;
        logic        e1;
    } vec_t;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic [31:0] tb_mem [1024];
    logic [31:0] gold [1024];
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [20];

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_be     (m0_be),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_be     (m1_be),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 1-cycle read latency, byte-enabled writes, preload under reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'h0;
            tb_mem[4] <= 32'hDEAD_BEEF;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr[11:2]];
            end
        end
    end

    task automatic gold_init();
        for (int i = 0; i < 1024; i++) gold[i] = 32'h0;
        gold[4] = 32'hDEAD_BEEF;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic w0, input logic [11:0] a0,
                                input logic [31:0] d0, input logic [3:0] b0,
                                input logic r1, input logic w1, input logic [11:0] a1,
                                input logic [31:0] d1, input logic [3:0] b1,
                                input logic lk, input logic e0, input logic e1);
        vec_t v;
        v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0; v.m0_be = b0;
        v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_wdata = d1; v.m1_be = b1;
        v.m1_lock = lk; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic drive_idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_lock = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m0_gnt"}, {31'b0, m0_gnt}, 0);
        chk({tag, "_m1_gnt"}, {31'b0, m1_gnt}, 0);
        chk({tag, "_mem_en"}, {31'b0, mem_en}, 0);
        chk({tag, "_m0_rvalid"}, {31'b0, m0_rvalid}, 0);
        chk({tag, "_m1_rvalid"}, {31'b0, m1_rvalid}, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
    endtask

    // One cycle: check last cycle's read response, drive v, check grants, push expectation.
    task automatic step(input vec_t v);
        exp_t        e;
        logic        we;
        logic [11:0] ad;
        logic [31:0] wd;
        logic [3:0]  be;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, e.own == 2'd1});
            chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, e.own == 2'd2});
            chk("m0_rdata", m0_rdata, (e.own == 2'd1) ? e.data : 32'h0);
            chk("m1_rdata", m1_rdata, (e.own == 2'd2) ? e.data : 32'h0);
        end
        m0_req = v.m0_req; m0_we = v.m0_we; m0_addr = v.m0_addr;
        m0_wdata = v.m0_wdata; m0_be = v.m0_be;
        m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr;
        m1_wdata = v.m1_wdata; m1_be = v.m1_be; m1_lock = v.m1_lock;
        #1;
        chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, v.e0});
        chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, v.e1});
        chk("mem_en", {31'b0, mem_en}, {31'b0, v.e0 | v.e1});
        e.own = 2'd0;
        e.data = 32'h0;
        if (v.e0 || v.e1) begin
            we = v.e1 ? v.m1_we : v.m0_we;
            ad = v.e1 ? v.m1_addr : v.m0_addr;
            wd = v.e1 ? v.m1_wdata : v.m0_wdata;
            be = v.e1 ? v.m1_be : v.m0_be;
            chk("mem_we", {31'b0, mem_we}, {31'b0, we});
            chk("mem_addr", {20'b0, mem_addr}, {20'b0, ad});
            if (we) begin
                chk("mem_wdata", mem_wdata, wd);
                chk("mem_be", {28'b0, mem_be}, {28'b0, be});
                for (int b = 0; b < 4; b++)
                    if (be[b]) gold[ad[11:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.own = v.e1 ? 2'd2 : 2'd1;
                e.data = gold[ad[11:2]];
            end
        end else begin
            chk("mem_we_idle", {31'b0, mem_we}, 0);
        end
        sb.push_back(e);
    endtask

    initial begin
        vec_t v;
        logic exp1;
        gold_init();
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst_n = 1;

        //            r0 w0 a0      d0            b0    r1 w1 a1      d1            b1    lk e0 e1
        tbl[0]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 12'h010, 32'h0,        4'h0, 1, 0, 12'h020, 32'h0,        4'h0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 1, 1, 12'h040, 32'h0000_00AA, 4'h1, 0, 0, 1);
        tbl[4]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 12'h040, 32'h0,        4'h0, 0, 0, 1);
        tbl[5]  = mk(1, 0, 12'h040, 32'h0,        4'h0, 1, 0, 12'h010, 32'h0,        4'h0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 12'h010, 32'h0,        4'h0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 12'h010, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 12'h000, 32'h0,        4'h0, 1, 1, 12'h080, 32'h1122_3344, 4'hF, 1, 0, 1);
        tbl[9]  = mk(1, 0, 12'h010, 32'h0,        4'h0, 1, 1, 12'h084, 32'h5566_7788, 4'hF, 1, 0, 1);
        tbl[10] = mk(1, 0, 12'h010, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 0);
        tbl[11] = mk(1, 0, 12'h010, 32'h0,        4'h0, 1, 1, 12'h088, 32'hCAFE_F00D, 4'hC, 1, 0, 1);
        tbl[12] = mk(1, 1, 12'h010, 32'h0,        4'hF, 0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 0);
        tbl[13] = mk(1, 0, 12'h010, 32'h0,        4'h0, 1, 1, 12'h08C, 32'hA5A5_5A5A, 4'hF, 1, 0, 1);
        tbl[14] = mk(1, 0, 12'h080, 32'h0,        4'h0, 1, 0, 12'h084, 32'h0,        4'h0, 0, 1, 0);
        tbl[15] = mk(0, 0, 12'h000, 32'h0,        4'h0, 1, 0, 12'h088, 32'h0,        4'h0, 0, 0, 1);
        tbl[16] = mk(1, 1, 12'h090, 32'h0BAD_F00D, 4'h3, 0, 0, 12'h000, 32'h0,       4'h0, 0, 1, 0);
        tbl[17] = mk(1, 0, 12'h08C, 32'h0,        4'h0, 1, 0, 12'h020, 32'h0,        4'h0, 1, 1, 0);
        tbl[18] = mk(1, 0, 12'h090, 32'h0,        4'h0, 1, 0, 12'h020, 32'h0,        4'h0, 1, 1, 0);
        tbl[19] = mk(0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 12'h000, 32'h0,        4'h0, 0, 0, 0);

        for (int i = 0; i < 20; i++) step(tbl[i]);

        // Both masters hold read requests: m1 only wins through the starvation counter.
        for (int i = 0; i < 12; i++) begin
`ifdef DMEM_ARB_STARVE_EN
            exp1 = (i == STARVE_MAX);
`else
            exp1 = 1'b0;
`endif
            v = mk(1, 0, 12'h010, 32'h0, 4'h0, 1, 0, 12'h020, 32'h0, 4'h0, 0, !exp1, exp1);
            step(v);
        end
        step(tbl[19]);
        step(tbl[19]);

        // Reset in the cycle after an m0 read grant drops the pending response.
        step(tbl[7]);
        @(negedge clk);
        drive_idle();
        rst_n = 0;
        #1;
        chk_quiet("mid_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        gold_init();
        #1;
        chk_quiet("post_rst");
        step(tbl[19]);
        step(tbl[19]);
        step(tbl[1]);
        step(tbl[19]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
